// File: rtl/axi_lite_req_arbiter_if.sv
// Bundle of the two requester command/response ports and the single-beat
// command port of the AXI4-Lite master. "master" is the arbiter's view.
interface axi_lite_req_arbiter_if #(
   parameter int ADDR_W = 32,
   parameter int DATA_W = 32
);
   localparam int STRB_W = DATA_W / 8;

   logic              r0_valid, r0_ready, r0_write, r0_done;
   logic [ADDR_W-1:0] r0_addr;
   logic [DATA_W-1:0] r0_wdata, r0_rdata;
   logic [STRB_W-1:0] r0_wstrb;
   logic [1:0]        r0_resp;

   logic              r1_valid, r1_ready, r1_write, r1_done;
   logic [ADDR_W-1:0] r1_addr;
   logic [DATA_W-1:0] r1_wdata, r1_rdata;
   logic [STRB_W-1:0] r1_wstrb;
   logic [1:0]        r1_resp;

   logic              m_valid, m_ready, m_write, m_done, m_abort;
   logic [ADDR_W-1:0] m_addr;
   logic [DATA_W-1:0] m_wdata, m_rdata;
   logic [STRB_W-1:0] m_wstrb;
   logic [1:0]        m_resp;

   modport master (
      input  r0_valid, r0_write, r0_addr, r0_wdata, r0_wstrb,
      output r0_ready, r0_done, r0_rdata, r0_resp,
      input  r1_valid, r1_write, r1_addr, r1_wdata, r1_wstrb,
      output r1_ready, r1_done, r1_rdata, r1_resp,
      output m_valid, m_write, m_addr, m_wdata, m_wstrb, m_abort,
      input  m_ready, m_done, m_rdata, m_resp
   );

   modport slave (
      output r0_valid, r0_write, r0_addr, r0_wdata, r0_wstrb,
      input  r0_ready, r0_done, r0_rdata, r0_resp,
      output r1_valid, r1_write, r1_addr, r1_wdata, r1_wstrb,
      input  r1_ready, r1_done, r1_rdata, r1_resp,
      input  m_valid, m_write, m_addr, m_wdata, m_wstrb, m_abort,
      output m_ready, m_done, m_rdata, m_resp
   );
endinterface

// File: rtl/axi_lite_req_arbiter.sv
// Two-requester round-robin arbiter/sequencer for the AXI4-Lite master's
// single-beat command port, with a watchdog that aborts hung transactions.
module axi_lite_req_arbiter #(
   parameter int ADDR_W  = 32,
   parameter int DATA_W  = 32,
   parameter int TIMEOUT = 256
) (
   input  logic                  ACLK,
   input  logic                  ARESET,
   axi_lite_req_arbiter_if.master bus,
   output logic                  busy,
   output logic                  grant
);
   localparam int STRB_W = DATA_W / 8;
   localparam int CW     = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
   localparam logic [CW-1:0] WD_LAST = CW'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);
   localparam logic [CW-1:0] WD_MAX  = CW'(TIMEOUT);

   localparam logic [1:0] IDLE  = 2'd0;
   localparam logic [1:0] ISSUE = 2'd1;
   localparam logic [1:0] WAIT  = 2'd2;
   localparam logic [1:0] RESP  = 2'd3;

   logic [1:0]                   state;
   logic                         last_grant, grant_q, abort_q;
   logic                         cmd_write;
   logic [ADDR_W-1:0]            cmd_addr;
   logic [DATA_W-1:0]            cmd_wdata;
   logic [STRB_W-1:0]            cmd_wstrb;
   logic [1:0][DATA_W-1:0]       rdata_q;
   logic [1:0][1:0]              resp_q;
   logic [CW-1:0]                wd_cnt;

   logic sel, accept, hs, done_in, in_txn, expire;

   // On a tie the requester that did not win last time is chosen.
   always_comb begin
      sel          = (bus.r0_valid && bus.r1_valid) ? ~last_grant : bus.r1_valid;
      bus.r0_ready = (state == IDLE) && bus.r0_valid && !sel;
      bus.r1_ready = (state == IDLE) && bus.r1_valid && sel;
      accept       = bus.r0_ready || bus.r1_ready;
      hs           = (state == ISSUE) && bus.m_ready;
      done_in      = (state == WAIT) && bus.m_done;
      in_txn       = (state == ISSUE) || (state == WAIT);
      // >= rather than == so a handshake landing on the last count cannot
      // push the saturated counter past the expiry point forever.
      expire       = (TIMEOUT > 0) && in_txn && (wd_cnt >= WD_LAST) && !hs && !done_in;
   end

   always_ff @(posedge ACLK) begin
      if (ARESET) begin
         state      <= IDLE;
         last_grant <= 1'b1;
         grant_q    <= 1'b0;
         abort_q    <= 1'b0;
         cmd_write  <= 1'b0;
         cmd_addr   <= '0;
         cmd_wdata  <= '0;
         cmd_wstrb  <= '0;
         rdata_q    <= '0;
         resp_q     <= '0;
         wd_cnt     <= '0;
      end else begin
         abort_q <= 1'b0;
         if (in_txn && wd_cnt != WD_MAX)
            wd_cnt <= wd_cnt + 1'b1;
         case (state)
            IDLE: if (accept) begin
               state     <= ISSUE;
               grant_q   <= sel;
               wd_cnt    <= '0;
               cmd_write <= sel ? bus.r1_write : bus.r0_write;
               cmd_addr  <= sel ? bus.r1_addr  : bus.r0_addr;
               cmd_wdata <= sel ? bus.r1_wdata : bus.r0_wdata;
               cmd_wstrb <= sel ? bus.r1_wstrb : bus.r0_wstrb;
            end
            ISSUE: if (hs) begin
               state <= WAIT;
            end else if (expire) begin
               state            <= RESP;
               abort_q          <= 1'b1;
               rdata_q[grant_q] <= '0;
               resp_q[grant_q]  <= 2'b10;
            end
            WAIT: if (done_in) begin
               state            <= RESP;
               resp_q[grant_q]  <= bus.m_resp;
               rdata_q[grant_q] <= cmd_write ? '0 : bus.m_rdata;
            end else if (expire) begin
               state            <= RESP;
               abort_q          <= 1'b1;
               rdata_q[grant_q] <= '0;
               resp_q[grant_q]  <= 2'b10;
            end
            default: begin
               last_grant <= grant_q;
               state      <= IDLE;
            end
         endcase
      end
   end

   always_comb begin
      busy         = (state != IDLE);
      grant        = grant_q;
      bus.m_valid  = (state == ISSUE);
      bus.m_write  = cmd_write;
      bus.m_addr   = cmd_addr;
      bus.m_wdata  = cmd_wdata;
      bus.m_wstrb  = cmd_wstrb;
      bus.m_abort  = abort_q;
      bus.r0_done  = (state == RESP) && !grant_q;
      bus.r1_done  = (state == RESP) && grant_q;
      bus.r0_rdata = rdata_q[0];
      bus.r1_rdata = rdata_q[1];
      bus.r0_resp  = resp_q[0];
      bus.r1_resp  = resp_q[1];
   end
endmodule

// File: tb/tb_axi_lite_req_arbiter.sv
// Directed bench for axi_lite_req_arbiter (watchdog set to 16 cycles).
module tb_axi_lite_req_arbiter;
   logic ACLK = 1'b0;
   logic ARESET = 1'b1;
   logic busy, grant;
   int   ncmp = 0;
   int   nerr = 0;
   int   c0, c1, e;
   logic [31:0] ea;

   axi_lite_req_arbiter_if #(.ADDR_W(32), .DATA_W(32)) bus ();

   axi_lite_req_arbiter #(.ADDR_W(32), .DATA_W(32), .TIMEOUT(16)) dut (
      .ACLK(ACLK), .ARESET(ARESET), .bus(bus), .busy(busy), .grant(grant)
   );

   always #5 ACLK = ~ACLK;

   initial begin
      #200000;
      $display("FAIL global_timeout");
      $fatal(1, "bench did not finish");
   end

   task automatic tick();
      @(posedge ACLK);
      #1;
   endtask

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      ncmp++;
      assert (obs === exp) else begin
         nerr++;
         $error("FAIL %s: got %0h want %0h", tag, obs, exp);
      end
   endtask

   initial begin
      bus.r0_valid = 0; bus.r0_write = 0; bus.r0_addr = 0; bus.r0_wdata = 0; bus.r0_wstrb = 0;
      bus.r1_valid = 0; bus.r1_write = 0; bus.r1_addr = 0; bus.r1_wdata = 0; bus.r1_wstrb = 0;
      bus.m_ready = 0; bus.m_done = 0; bus.m_rdata = 0; bus.m_resp = 0;

      // reset state
      tick(); tick();
      chk("rst_busy", busy, 0);
      chk("rst_mvalid", bus.m_valid, 0);
      chk("rst_grant", grant, 0);
      chk("rst_maddr", bus.m_addr, 0);
      chk("rst_r0rdata", bus.r0_rdata, 0);
      chk("rst_abort", bus.m_abort, 0);
      ARESET = 0;

      // single write from r0
      bus.r0_valid = 1; bus.r0_write = 1; bus.r0_addr = 32'h10; bus.r0_wdata = 32'h1; bus.r0_wstrb = 4'hF;
      bus.m_ready = 1;
      #1;
      chk("w_r0ready", bus.r0_ready, 1);
      chk("w_r1ready", bus.r1_ready, 0);
      tick();
      bus.r0_valid = 0;
      chk("w_mvalid", bus.m_valid, 1);
      chk("w_mwrite", bus.m_write, 1);
      chk("w_maddr", bus.m_addr, 32'h10);
      chk("w_mwdata", bus.m_wdata, 32'h1);
      chk("w_mwstrb", bus.m_wstrb, 4'hF);
      chk("w_grant", grant, 0);
      tick();
      chk("w_mvalid_drop", bus.m_valid, 0);
      bus.m_done = 1; bus.m_resp = 0; bus.m_rdata = 32'h1234;
      tick();
      bus.m_done = 0;
      chk("w_r0done", bus.r0_done, 1);
      chk("w_r1done", bus.r1_done, 0);
      chk("w_r0resp", bus.r0_resp, 0);
      chk("w_r0rdata", bus.r0_rdata, 0);
      tick();
      chk("w_done_pulse", bus.r0_done, 0);
      chk("w_idle", busy, 0);

      // single read from r1, 5 WAIT cycles
      bus.r1_valid = 1; bus.r1_write = 0; bus.r1_addr = 32'h14;
      #1;
      chk("r_r1ready", bus.r1_ready, 1);
      tick();
      bus.r1_valid = 0;
      chk("r_grant", grant, 1);
      chk("r_maddr", bus.m_addr, 32'h14);
      chk("r_mwrite", bus.m_write, 0);
      tick();
      for (int i = 0; i < 4; i++) begin
         chk("r_wait_nodone", bus.r1_done, 0);
         tick();
      end
      bus.m_done = 1; bus.m_rdata = 32'hDEAD_BEEF; bus.m_resp = 0;
      tick();
      bus.m_done = 0;
      chk("r_r1done", bus.r1_done, 1);
      chk("r_r1rdata", bus.r1_rdata, 32'hDEAD_BEEF);
      chk("r_r1resp", bus.r1_resp, 0);
      chk("r_r0rdata_hold", bus.r0_rdata, 0);
      tick();

      // backpressure: m_ready low for 10 ISSUE cycles
      bus.m_ready = 0;
      bus.r0_valid = 1; bus.r0_write = 0; bus.r0_addr = 32'h20;
      tick();
      bus.r0_valid = 0;
      for (int i = 0; i < 10; i++) begin
         chk("bp_mvalid", bus.m_valid, 1);
         chk("bp_maddr", bus.m_addr, 32'h20);
         tick();
      end
      chk("bp_mvalid_11", bus.m_valid, 1);
      bus.m_ready = 1;
      tick();
      chk("bp_wait", bus.m_valid, 0);
      bus.m_done = 1; bus.m_rdata = 32'hA5A5; bus.m_resp = 2'b01;
      tick();
      bus.m_done = 0; bus.m_resp = 0;
      chk("bp_r0done", bus.r0_done, 1);
      chk("bp_r0resp", bus.r0_resp, 2'b01);
      chk("bp_r0rdata", bus.r0_rdata, 32'hA5A5);
      tick();

      // contention from reset: 3 commands each
      ARESET = 1; tick(); ARESET = 0;
      c0 = 0; c1 = 0; e = 0;
      for (int t = 0; t < 6; t++) begin
         bus.r0_valid = (c0 < 3); bus.r0_write = 0; bus.r0_addr = 32'h100 + c0 * 4;
         bus.r1_valid = (c1 < 3); bus.r1_write = 0; bus.r1_addr = 32'h200 + c1 * 4;
         ea = (e == 0) ? 32'h100 + c0 * 4 : 32'h200 + c1 * 4;
         #1;
         chk("ct_r0ready", bus.r0_ready, (e == 0));
         chk("ct_r1ready", bus.r1_ready, (e == 1));
         tick();
         if (e == 0) c0++; else c1++;
         chk("ct_grant", grant, e);
         chk("ct_maddr", bus.m_addr, ea);
         chk("ct_noready_issue", {bus.r0_ready, bus.r1_ready}, 2'b00);
         tick();
         chk("ct_noready_wait", {bus.r0_ready, bus.r1_ready}, 2'b00);
         bus.m_done = 1; bus.m_rdata = t;
         tick();
         bus.m_done = 0;
         chk("ct_done", {bus.r1_done, bus.r0_done}, (e == 0) ? 2'b01 : 2'b10);
         chk("ct_rdata", (e == 0) ? bus.r0_rdata : bus.r1_rdata, t);
         chk("ct_noready_resp", {bus.r0_ready, bus.r1_ready}, 2'b00);
         tick();
         e = 1 - e;
      end
      bus.r0_valid = 0; bus.r1_valid = 0;

      // watchdog: no m_done, expiry after 16 ISSUE+WAIT cycles
      bus.r0_valid = 1; bus.r0_write = 0; bus.r0_addr = 32'h30;
      #1;
      chk("to_r0ready", bus.r0_ready, 1);
      tick();
      bus.r0_valid = 0;
      for (int k = 1; k <= 16; k++) begin
         chk("to_nodone", {busy, bus.r0_done, bus.m_abort}, 3'b100);
         tick();
      end
      chk("to_abort", bus.m_abort, 1);
      chk("to_r0done", bus.r0_done, 1);
      chk("to_r0resp", bus.r0_resp, 2'b10);
      chk("to_r0rdata", bus.r0_rdata, 0);
      chk("to_mvalid", bus.m_valid, 0);
      tick();
      chk("to_abort_pulse", bus.m_abort, 0);
      chk("to_idle", busy, 0);

      // reset in the middle of WAIT
      bus.r1_valid = 1; bus.r1_write = 0; bus.r1_addr = 32'h40;
      tick();
      bus.r1_valid = 0;
      tick();
      tick();
      chk("rw_inwait", busy, 1);
      ARESET = 1;
      tick();
      ARESET = 0;
      chk("rw_busy", busy, 0);
      chk("rw_mvalid", bus.m_valid, 0);
      chk("rw_nodone", {bus.r0_done, bus.r1_done}, 2'b00);
      bus.m_done = 1;
      tick();
      bus.m_done = 0;
      chk("rw_mdone_ignored", {busy, bus.r0_done, bus.r1_done}, 3'b000);
      bus.r0_valid = 1; bus.r1_valid = 1;
      #1;
      chk("rw_tie_r0", bus.r0_ready, 1);
      chk("rw_tie_r1", bus.r1_ready, 0);
      bus.r0_valid = 0; bus.r1_valid = 0;
      tick();

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nerr);
      $finish;
   end
endmodule

// File: doc/axi_lite_req_arbiter.md
Name: axi_lite_req_arbiter

Overview:
- Two-requester, round-robin arbiter and transaction sequencer in front of the AXI4-Lite master's single-beat user command port.
- Accepts one read or write command at a time and holds it on the master until the master accepts it.
- Waits for completion, then returns read data and response to the winning requester.
- A watchdog aborts hung transactions so peripherals such as the LED on/off slave cannot deadlock the system.

Parameters:
ADDR_W, 32, address width
DATA_W, 32, data width; strobe width is DATA_W/8
TIMEOUT, 256, max cycles from ISSUE entry to m_done; 0 disables watchdog

Ports:
ACLK  in  1  clock, all logic on rising edge
ARESET  in  1  synchronous reset, active-high
rN_valid  in  1  requester N (N=0,1) command valid
rN_ready  out  1  command accepted (combinational, see Behaviour)
rN_write  in  1  1=write, 0=read
rN_addr  in  ADDR_W  address
rN_wdata  in  DATA_W  write data
rN_wstrb  in  DATA_W/8  write strobes
rN_done  out  1  one-cycle completion pulse
rN_rdata  out  DATA_W  read data, valid with rN_done
rN_resp  out  2  response, valid with rN_done
m_valid  out  1  command valid to master
m_ready  in  1  master accepted command
m_write  out  1  latched direction
m_addr  out  ADDR_W  latched address
m_wdata  out  DATA_W  latched write data
m_wstrb  out  DATA_W/8  latched strobes
m_done  in  1  master completion pulse (B or R handshake done)
m_rdata  in  DATA_W  read data, valid with m_done
m_resp  in  2  BRESP/RRESP, valid with m_done
m_abort  out  1  one-cycle pulse on watchdog expiry; master resets its channel FSMs
busy  out  1  state != IDLE
grant  out  1  index of current/last granted requester

Behaviour:
- Reset (ARESET=1 at edge): state=IDLE; last_grant=1, so r0 wins the first tie.
  - All outputs 0, including command regs, rdata/resp regs and watchdog counter.
  - An in-flight transaction is dropped with no rN_done.
- States: IDLE, ISSUE, WAIT, RESP.
- IDLE:
  - rN_ready = (state==IDLE) && rN_valid && selected(N).
  - Only one valid: select it. Both valid: select the requester != last_grant.
  - On the rN_valid&&rN_ready edge: latch write/addr/wdata/wstrb, set grant=N, go to ISSUE.
  - Requesters hold valid and all fields stable until ready.
- ISSUE:
  - m_valid=1 with latched fields, held stable until m_ready.
  - On m_valid&&m_ready edge: go to WAIT, m_valid=0 next cycle. m_ready may be 1 on the first ISSUE cycle.
- WAIT:
  - On m_done: capture m_resp; capture m_rdata for reads, 0 for writes; go to RESP.
- Watchdog (TIMEOUT>0):
  - Counter clears on entry to ISSUE and increments every cycle in ISSUE/WAIT.
  - Width is clog2(TIMEOUT+1), saturating.
  - When the counter == TIMEOUT-1 and no m_done/handshake completes that cycle, go to RESP with resp=2'b10 (SLVERR), rdata=0. Also pulse m_abort and drop m_valid.
  - If m_done and expiry coincide, m_done wins.
- RESP (exactly 1 cycle):
  - r[grant]_done=1; set last_grant=grant; go to IDLE.
- rN_rdata/rN_resp are registered and hold until that requester's next completion.
- m_done outside WAIT is ignored.
- Minimum latency, accept edge to rN_done: 3 cycles (ISSUE 1, WAIT 1, RESP 1), with m_ready=1 immediately and m_done on the first WAIT cycle.
- Throughput: at most one transaction in flight; no new accept until back in IDLE.
- The non-granted requester's ready stays 0 for the whole transaction and its valid is held; fairness means it wins the next arbitration if still valid.

Test Plan:
- Single write: r0 write addr=0x0000_0010, wdata=0x0000_0001, wstrb=0xF; master m_ready=1, m_done one cycle after with resp=0 -> m_valid 1 cycle with those values; r0_done 3 cycles after accept, r0_resp=0, r0_rdata=0.
- Single read: r1 read addr=0x0000_0014; m_done with m_rdata=0xDEAD_BEEF after 5 WAIT cycles -> r1_done pulse, r1_rdata=0xDEAD_BEEF, r1_resp=0, grant=1.
- Contention: r0 and r1 valid together from reset, each issuing 3 commands back-to-back -> grant order 0,1,0,1,0,1; no double accept; r1_ready never high while busy.
- Backpressure: m_ready low 10 cycles in ISSUE -> m_valid and m_addr stable all 10 cycles; single accept.
- Timeout: TIMEOUT=16, m_done never asserted -> m_abort pulse and r0_done after exactly 16 ISSUE+WAIT cycles, r0_resp=2'b10, r0_rdata=0.
- Reset mid-WAIT: ARESET high 1 cycle -> busy=0, m_valid=0, no rN_done, next tie grants r0.
